// File: rtl/thermo_expand16_pipe.sv
// Count-to-thermometer expander with a LATENCY-deep valid/ready pipeline.
// Optional range-error flag: define THERMO_RANGE_CHECK_EN.
module thermo_expand16_pipe #(
   parameter int unsigned N         = 16,
   parameter int unsigned CW        = 5,
   parameter int unsigned LATENCY   = 3,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_count,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_word,
   output logic [CW-1:0] out_count,
   output logic          out_err
);

   localparam logic [CW-1:0] NCnt = CW'(N);

   // Stage 0 carries a one-hot code: bit j set means K = j + 1; K >= N lands on the top bit.
   function automatic logic [N-1:0] to_thermo(input logic [N-1:0] oh);
      logic [N-1:0] t;
      logic [N-1:0] r;
      logic         acc;
      acc = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         acc  = acc | oh[i];
         t[i] = acc;
      end
      r = t;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < int'(N); i++) begin
            r[int'(N) - 1 - i] = t[i];
         end
      end
      return r;
   endfunction

   logic                adv;
   logic [N-1:0]        onehot;
   logic [LATENCY-1:0]  valid_q, valid_d;
   logic [N-1:0]        word_q  [LATENCY];
   logic [N-1:0]        word_d  [LATENCY];
   logic [CW-1:0]       cnt_q   [LATENCY];
   logic [CW-1:0]       cnt_d   [LATENCY];

   assign out_valid = valid_q[LATENCY-1];
   assign adv       = out_ready | ~out_valid;
   assign in_ready  = adv;
   assign out_count = cnt_q[LATENCY-1];

   always_comb begin
      onehot = '0;
      for (int j = 0; j < int'(N) - 1; j++) begin
         onehot[j] = (in_count == CW'(j + 1));
      end
      onehot[N-1] = (in_count >= NCnt);
   end

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      if (adv) begin
         valid_d[0] = in_valid;
         word_d[0]  = onehot;
         cnt_d[0]   = in_count;
         for (int s = 1; s < int'(LATENCY); s++) begin
            valid_d[s] = valid_q[s-1];
            word_d[s]  = (s == 1) ? to_thermo(word_q[0]) : word_q[s-1];
            cnt_d[s]   = cnt_q[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int s = 0; s < int'(LATENCY); s++) begin
            word_q[s] <= '0;
            cnt_q[s]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end

   if (LATENCY == 1) begin : g_lat1
      assign out_word = to_thermo(word_q[0]);
   end else begin : g_latn
      assign out_word = word_q[LATENCY-1];
   end

`ifdef THERMO_RANGE_CHECK_EN
   logic [LATENCY-1:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (adv) begin
         err_d[0] = in_valid & (in_count > NCnt);
         for (int s = 1; s < int'(LATENCY); s++) begin
            err_d[s] = err_q[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign out_err = err_q[LATENCY-1];
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_thermo_expand16_pipe.sv
// Directed and random self-checking bench for thermo_expand16_pipe.
module tb_thermo_expand16_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [4:0]  in_count;
   logic        in_ready, out_valid, out_err;
   logic [15:0] out_word;
   logic [4:0]  out_count;
   logic        m_in_ready, m_out_valid, m_out_err;
   logic [15:0] m_out_word;
   logic [4:0]  m_out_count;
   int          n_checks = 0;
   int          n_fail   = 0;

`ifdef THERMO_RANGE_CHECK_EN
   localparam logic ExpErr = 1'b1;
`else
   localparam logic ExpErr = 1'b0;
`endif

   always #5 clk = ~clk;

   thermo_expand16_pipe #(.N(16), .CW(5), .LATENCY(3), .MSB_FIRST(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_count(out_count), .out_err(out_err)
   );

   thermo_expand16_pipe #(.N(16), .CW(5), .LATENCY(3), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_count(in_count),
      .out_valid(m_out_valid), .out_ready(out_ready), .out_word(m_out_word),
      .out_count(m_out_count), .out_err(m_out_err)
   );

   function automatic logic [15:0] model_lsb(input int k);
      if (k >= 16) return 16'hFFFF;
      return 16'((32'd1 << k) - 32'd1);
   endfunction

   function automatic logic [15:0] model_msb(input int k);
      logic [15:0] a;
      logic [15:0] r;
      a = model_lsb(k);
      for (int i = 0; i < 16; i++) r[15 - i] = a[i];
      return r;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_count = 5'd5; out_ready = 1'b1;
      repeat (2) begin
         next_cycle();
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
         end
      end
      next_cycle();
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      n_checks++;
      if ({out_valid, out_word, out_count, out_err} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b w=%h c=%0d e=%b want all 0",
                  out_valid, out_word, out_count, out_err);
      end
      repeat (4) begin
         next_cycle();
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_leak: got %b want 0", out_valid);
         end
      end
   endtask

   task automatic test_sweep();
      int k;
      out_ready = 1'b1;
      for (int c = 0; c < 21; c++) begin
         next_cycle();
         in_valid = (c <= 16);
         in_count = 5'(c);
         @(negedge clk);
         if (c >= 3 && c <= 19) begin
            k = c - 3;
            n_checks++;
            if (out_valid !== 1'b1 || out_word !== model_lsb(k) || out_count !== 5'(k)) begin
               n_fail++;
               $display("FAIL sweep_lsb k=%0d: got v=%b w=%h c=%0d want v=1 w=%h c=%0d",
                        k, out_valid, out_word, out_count, model_lsb(k), k);
            end
            n_checks++;
            if (m_out_word !== model_msb(k)) begin
               n_fail++;
               $display("FAIL sweep_msb k=%0d: got %h want %h", k, m_out_word, model_msb(k));
            end
         end else begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_fail++; $display("FAIL sweep_latency c=%0d: got v=%b want 0", c, out_valid);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] expw [4];
      int          got;
      expw = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};
      got  = 0;
      for (int c = 0; c < 16; c++) begin
         next_cycle();
         in_valid  = (c < 4);
         in_count  = 5'(c + 1);
         out_ready = !(c >= 4 && c <= 8);
         @(negedge clk);
         if (c >= 4 && c <= 8) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_word !== 16'h0003) begin
               n_fail++;
               $display("FAIL bp_hold c=%0d: got v=%b w=%h want v=1 w=0003", c, out_valid, out_word);
            end
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (got >= 4) begin
               n_fail++; $display("FAIL bp_duplicate: got extra word %h want none", out_word);
            end else if (out_word !== expw[got]) begin
               n_fail++; $display("FAIL bp_order #%0d: got %h want %h", got, out_word, expw[got]);
            end
            got++;
         end
      end
      n_checks++;
      if (got != 4) begin
         n_fail++; $display("FAIL bp_count: got %0d words want 4", got);
      end
   endtask

   task automatic test_range();
      logic [4:0] ks [2];
      int         got;
      ks  = '{5'd20, 5'd31};
      got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         in_valid = (c < 2);
         in_count = (c == 0) ? 5'd20 : 5'd31;
         @(negedge clk);
         if (out_valid && out_ready) begin
            n_checks++;
            if (got >= 2) begin
               n_fail++; $display("FAIL range_extra: got word %h want none", out_word);
            end else if (out_word !== 16'hFFFF || out_err !== ExpErr ||
                         out_count !== ks[got] || m_out_word !== 16'hFFFF) begin
               n_fail++;
               $display("FAIL range k=%0d: got w=%h e=%b c=%0d mw=%h want w=FFFF e=%b c=%0d mw=FFFF",
                        ks[got], out_word, out_err, out_count, m_out_word, ExpErr, ks[got]);
            end
            got++;
         end
      end
      n_checks++;
      if (got != 2) begin
         n_fail++; $display("FAIL range_count: got %0d words want 2", got);
      end
   endtask

   task automatic test_midreset();
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         next_cycle();
         in_valid = (c < 2);
         in_count = (c == 0) ? 5'd3 : 5'd6;
         rst      = (c == 2);
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_quiet c=%0d: got v=%b want 0", c, out_valid);
         end
      end
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         in_valid = (c == 0);
         in_count = 5'd9;
         @(negedge clk);
         n_checks++;
         if (out_valid !== (c == 3) || (c == 3 && out_word !== 16'h01FF)) begin
            n_fail++;
            $display("FAIL midreset_resume c=%0d: got v=%b w=%h want v=%b w=01FF",
                     c, out_valid, out_word, (c == 3));
         end
      end
   endtask

   task automatic test_loopback();
      int unsigned q [$];
      int          xfers, cycles;
      logic        held_v;
      logic [15:0] held_w;
      logic [4:0]  held_c;
      xfers = 0; cycles = 0; held_v = 1'b0; held_w = '0; held_c = '0;
      while (xfers < 1000 && cycles < 20000) begin
         next_cycle();
         in_valid  = ($urandom_range(0, 3) != 0);
         in_count  = 5'($urandom_range(0, 16));
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         cycles++;
         if (held_v) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_word !== held_w || out_count !== held_c) begin
               n_fail++;
               $display("FAIL loop_stable: got v=%b w=%h c=%0d want v=1 w=%h c=%0d",
                        out_valid, out_word, out_count, held_w, held_c);
            end
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL loop_spurious: got word %h want none", out_word);
            end else begin
               if ($countones(out_word) != int'(out_count) || out_count !== 5'(q[0]) ||
                   out_word !== model_lsb(int'(q[0])) || out_err !== 1'b0) begin
                  n_fail++;
                  $display("FAIL loop_xfer #%0d: got w=%h c=%0d e=%b want w=%h c=%0d e=0",
                           xfers, out_word, out_count, out_err, model_lsb(int'(q[0])), q[0]);
               end
               void'(q.pop_front());
            end
            xfers++;
         end
         held_v = out_valid && !out_ready;
         held_w = out_word;
         held_c = out_count;
         if (in_valid && in_ready) q.push_back(int'(in_count));
      end
      n_checks++;
      if (xfers < 1000) begin
         n_fail++; $display("FAIL loop_budget: got %0d transfers want 1000", xfers);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sweep();
      test_backpressure();
      test_range();
      test_midreset();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
